// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: default geometry, derived
// tag width, FSM state encoding and the word-alignment helper.
package icache_pkg;

  localparam int ICACHE_IDX_W  = 8;
  localparam int ICACHE_ADDR_W = 32;
  localparam int ICACHE_TAG_W  = ICACHE_ADDR_W - ICACHE_IDX_W - 2;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_e;

  // Clears the byte-offset bits so the miss address is always word aligned.
  function automatic logic [ICACHE_ADDR_W-1:0] word_align(input logic [ICACHE_ADDR_W-1:0] a);
    return {a[ICACHE_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side handshake signals of the icache.
// The slave modport is the cache's view; master is the fetch stage plus
// memory controller environment around it.
interface icache_if #(
  parameter int ADDR_W = 32
);

  logic              IF_S;
  logic [ADDR_W-1:0] IF_pos;
  logic              IF_ready;
  logic              IF_success;
  logic [31:0]       IF_inst;
  logic              IC_S;
  logic [ADDR_W-1:0] IC_pos;
  logic              IC_success;
  logic [31:0]       IC_value;

  modport slave (
    input  IF_S, IF_pos, IC_success, IC_value,
    output IF_ready, IF_success, IF_inst, IC_S, IC_pos
  );

  modport master (
    output IF_S, IF_pos, IC_success, IC_value,
    input  IF_ready, IF_success, IF_inst, IC_S, IC_pos
  );

endinterface

// File: rtl/icache_array.sv
// Storage for the direct-mapped cache: valid bits, tags and one data word
// per line. Combinational read port, synchronous write port. Only the valid
// bits are reset; tag and data contents are meaningless until written.
module icache_array
  import icache_pkg::*;
#(
  parameter int IDX_W  = ICACHE_IDX_W,
  parameter int TAG_W  = ICACHE_TAG_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] data [LINES];

  // Valid bits: cleared on reset, set when a line is filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data write port; a fill simply overwrites whatever was there.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch
// stage and the memory controller. Hits return one cycle after the request;
// a miss issues a single outstanding read and installs the returned word.
// A flush (clr) abandons an in-flight miss but keeps the cache contents.
// Optional build macro ICACHE_STAT_EN adds hit/miss counter outputs.
module icache
  import icache_pkg::*;
#(
  parameter int IDX_W  = ICACHE_IDX_W,
  parameter int ADDR_W = ICACHE_ADDR_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  icache_if.slave     bus
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  state_e            state_q, state_d;
  logic              success_q, success_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] ic_pos_q, ic_pos_d;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              hit;
  logic              accept;
  logic              fill_we;
  logic              unused_bits;

  assign hit    = rd_valid && (rd_tag == bus.IF_pos[ADDR_W-1:IDX_W+2]);
  assign accept = !clr && rdy && (state_q == IDLE) && bus.IF_S;

  // A fill lands in the array even when a flush cancels its return to IF.
  assign fill_we = (state_q == MISS) && bus.IC_success && (clr || rdy);

  assign unused_bits = ^{bus.IF_pos[1:0], ic_pos_q[1:0]};

  icache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .DATA_W(32)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (bus.IF_pos[IDX_W+1:2]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .we      (fill_we),
    .wr_idx  (ic_pos_q[IDX_W+1:2]),
    .wr_tag  (ic_pos_q[ADDR_W-1:IDX_W+2]),
    .wr_data (bus.IC_value)
  );

  // State and response registers; everything else is derived combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      success_q <= 1'b0;
      inst_q    <= '0;
      ic_pos_q  <= '0;
    end else begin
      state_q   <= state_d;
      success_q <= success_d;
      inst_q    <= inst_d;
      ic_pos_q  <= ic_pos_d;
    end
  end

  // Next state and response: flush beats stall, stall beats normal operation.
  always_comb begin
    state_d   = state_q;
    success_d = 1'b0;
    inst_d    = inst_q;
    ic_pos_d  = ic_pos_q;
    if (clr) begin
      state_d = IDLE;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if (bus.IF_S) begin
            if (hit) begin
              success_d = 1'b1;
              inst_d    = rd_data;
            end else begin
              ic_pos_d = word_align(bus.IF_pos);
              state_d  = MISS;
            end
          end
        end
        MISS: begin
          if (bus.IC_success) begin
            success_d = 1'b1;
            inst_d    = bus.IC_value;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.IF_ready   = (state_q == IDLE);
  assign bus.IF_success = success_q;
  assign bus.IF_inst    = inst_q;
  assign bus.IC_S       = (state_q == MISS) && !bus.IC_success;
  assign bus.IC_pos     = ic_pos_q;

`ifdef ICACHE_STAT_EN
  // Hit/miss counters for accepted requests; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetch
// traffic, all checked against a line-level reference model of the cache.
module tb_icache;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, clr;

  icache_if bus ();

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .clr(clr),
    .bus(bus)
`ifdef ICACHE_STAT_EN
    ,
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: per line, whether it holds a word, which address, what value.
  bit          m_valid [256];
  logic [31:0] m_addr  [256];
  logic [31:0] m_data  [256];
  int exp_hits, exp_misses;
  int nchk, nfail;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    int idx;
    idx = int'(a[9:2]);
    return m_valid[idx] && (m_addr[idx][31:10] == a[31:10]);
  endfunction

  task automatic model_fill(input logic [31:0] a, input logic [31:0] v);
    int idx;
    idx = int'(a[9:2]);
    m_valid[idx] = 1'b1;
    m_addr[idx]  = {a[31:2], 2'b00};
    m_data[idx]  = v;
  endtask

  // One complete fetch with the memory controller answering after lat cycles.
  task automatic fetch(input logic [31:0] a, input logic [31:0] fill, input int lat, input string nm);
    bit h;
    int idx;
    h   = model_hit(a);
    idx = int'(a[9:2]);
    nchk++; if (bus.IF_ready !== 1'b1) begin nfail++; $display("[TB] FAIL %s ready: got %0b want 1", nm, bus.IF_ready); end
    bus.IF_S   = 1'b1;
    bus.IF_pos = a;
    step();
    bus.IF_S = 1'b0;
    if (h) begin
      exp_hits++;
      nchk++; if (bus.IF_success !== 1'b1) begin nfail++; $display("[TB] FAIL %s hit_success: got %0b want 1", nm, bus.IF_success); end
      nchk++; if (bus.IF_inst !== m_data[idx]) begin nfail++; $display("[TB] FAIL %s hit_inst: got %h want %h", nm, bus.IF_inst, m_data[idx]); end
      nchk++; if (bus.IC_S !== 1'b0) begin nfail++; $display("[TB] FAIL %s hit_ic_s: got %0b want 0", nm, bus.IC_S); end
    end else begin
      exp_misses++;
      nchk++; if (bus.IF_success !== 1'b0) begin nfail++; $display("[TB] FAIL %s miss_success: got %0b want 0", nm, bus.IF_success); end
      nchk++; if (bus.IC_S !== 1'b1) begin nfail++; $display("[TB] FAIL %s miss_ic_s: got %0b want 1", nm, bus.IC_S); end
      nchk++; if (bus.IC_pos !== {a[31:2], 2'b00}) begin nfail++; $display("[TB] FAIL %s ic_pos: got %h want %h", nm, bus.IC_pos, {a[31:2], 2'b00}); end
      nchk++; if (bus.IF_ready !== 1'b0) begin nfail++; $display("[TB] FAIL %s miss_ready: got %0b want 0", nm, bus.IF_ready); end
      for (int i = 1; i < lat; i++) begin
        step();
        nchk++; if (bus.IC_S !== 1'b1 || bus.IF_success !== 1'b0) begin nfail++; $display("[TB] FAIL %s wait: got ic_s=%0b success=%0b want 1/0", nm, bus.IC_S, bus.IF_success); end
      end
      bus.IC_success = 1'b1;
      bus.IC_value   = fill;
      #1;
      nchk++; if (bus.IC_S !== 1'b0) begin nfail++; $display("[TB] FAIL %s ic_s_drop: got %0b want 0", nm, bus.IC_S); end
      step();
      bus.IC_success = 1'b0;
      nchk++; if (bus.IF_success !== 1'b1) begin nfail++; $display("[TB] FAIL %s fill_success: got %0b want 1", nm, bus.IF_success); end
      nchk++; if (bus.IF_inst !== fill) begin nfail++; $display("[TB] FAIL %s fill_inst: got %h want %h", nm, bus.IF_inst, fill); end
      model_fill(a, fill);
    end
    step();
    nchk++; if (bus.IF_success !== 1'b0) begin nfail++; $display("[TB] FAIL %s single_pulse: got %0b want 0", nm, bus.IF_success); end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    bus.IF_S = 1'b0; bus.IF_pos = '0; bus.IC_success = 1'b0; bus.IC_value = '0;
    step();
    step();
    rst = 1'b0;
    model_reset();
    nchk++; if (bus.IF_ready !== 1'b1) begin nfail++; $display("[TB] FAIL reset_ready: got %0b want 1", bus.IF_ready); end
    nchk++; if (bus.IF_success !== 1'b0) begin nfail++; $display("[TB] FAIL reset_success: got %0b want 0", bus.IF_success); end
    nchk++; if (bus.IF_inst !== 32'h0) begin nfail++; $display("[TB] FAIL reset_inst: got %h want 0", bus.IF_inst); end
    nchk++; if (bus.IC_pos !== 32'h0) begin nfail++; $display("[TB] FAIL reset_ic_pos: got %h want 0", bus.IC_pos); end
    nchk++; if (bus.IC_S !== 1'b0) begin nfail++; $display("[TB] FAIL reset_ic_s: got %0b want 0", bus.IC_S); end
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_0010, 32'h0000_0513, 3, "cold_miss");
  endtask

  task automatic test_hit_stream();
    fetch(32'h0000_0010, 32'hDEAD_0000, 2, "hit");
    fetch(32'h0000_0014, 32'h0000_0613, 1, "fill14");
    bus.IF_S = 1'b1; bus.IF_pos = 32'h10;
    step();
    exp_hits++;
    nchk++; if (bus.IF_success !== 1'b1 || bus.IF_inst !== 32'h0000_0513) begin nfail++; $display("[TB] FAIL stream0: got %0b/%h want 1/00000513", bus.IF_success, bus.IF_inst); end
    bus.IF_pos = 32'h14;
    step();
    exp_hits++;
    bus.IF_S = 1'b0;
    nchk++; if (bus.IF_success !== 1'b1 || bus.IF_inst !== 32'h0000_0613) begin nfail++; $display("[TB] FAIL stream1: got %0b/%h want 1/00000613", bus.IF_success, bus.IF_inst); end
    step();
  endtask

  task automatic test_conflict();
    fetch(32'h0000_0410, 32'hA5A5_0410, 2, "conflict_new");
    fetch(32'h0000_0010, 32'h0000_0513, 2, "conflict_old");
  endtask

  task automatic test_flush();
    bus.IF_S = 1'b1; bus.IF_pos = 32'h20;
    exp_misses++;
    step();
    bus.IF_S = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    nchk++; if (bus.IC_S !== 1'b0 || bus.IF_ready !== 1'b1) begin nfail++; $display("[TB] FAIL flush_idle: got ic_s=%0b ready=%0b want 0/1", bus.IC_S, bus.IF_ready); end
    nchk++; if (bus.IF_success !== 1'b0) begin nfail++; $display("[TB] FAIL flush_success: got %0b want 0", bus.IF_success); end
    bus.IF_S = 1'b1;
    exp_misses++;
    step();
    bus.IF_S = 1'b0;
    nchk++; if (bus.IC_S !== 1'b1) begin nfail++; $display("[TB] FAIL flush2_ic_s: got %0b want 1", bus.IC_S); end
    bus.IC_success = 1'b1; bus.IC_value = 32'h0020_0093; clr = 1'b1;
    step();
    bus.IC_success = 1'b0; clr = 1'b0;
    model_fill(32'h20, 32'h0020_0093);
    nchk++; if (bus.IF_success !== 1'b0 || bus.IF_ready !== 1'b1) begin nfail++; $display("[TB] FAIL flush_fill: got success=%0b ready=%0b want 0/1", bus.IF_success, bus.IF_ready); end
    fetch(32'h0000_0020, 32'hBAD0_0020, 2, "after_flush");
  endtask

  task automatic test_rdy();
    rdy = 1'b0; bus.IF_S = 1'b1; bus.IF_pos = 32'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      nchk++; if (bus.IF_success !== 1'b0 || bus.IF_ready !== 1'b1) begin nfail++; $display("[TB] FAIL rdy_hold%0d: got success=%0b ready=%0b want 0/1", i, bus.IF_success, bus.IF_ready); end
    end
    rdy = 1'b1;
    step();
    bus.IF_S = 1'b0;
    exp_hits++;
    nchk++; if (bus.IF_success !== 1'b1 || bus.IF_inst !== m_data[4]) begin nfail++; $display("[TB] FAIL rdy_resume: got %0b/%h want 1/%h", bus.IF_success, bus.IF_inst, m_data[4]); end
    step();
  endtask

  task automatic test_reset_miss();
    bus.IF_S = 1'b1; bus.IF_pos = 32'h40;
    step();
    bus.IF_S = 1'b0;
    nchk++; if (bus.IC_S !== 1'b1) begin nfail++; $display("[TB] FAIL rst_miss_ic_s: got %0b want 1", bus.IC_S); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    nchk++; if (bus.IC_S !== 1'b0 || bus.IF_ready !== 1'b1) begin nfail++; $display("[TB] FAIL rst_miss_idle: got ic_s=%0b ready=%0b want 0/1", bus.IC_S, bus.IF_ready); end
    fetch(32'h0000_0010, 32'h1111_0010, 1, "rst_invalid");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      fetch(a, $urandom, int'($urandom_range(1, 4)), "rand");
    end
  endtask

  task automatic test_stats(input string nm);
`ifdef ICACHE_STAT_EN
    nchk++; if (hit_cnt !== 32'(exp_hits)) begin nfail++; $display("[TB] FAIL %s hit_cnt: got %0d want %0d", nm, hit_cnt, exp_hits); end
    nchk++; if (miss_cnt !== 32'(exp_misses)) begin nfail++; $display("[TB] FAIL %s miss_cnt: got %0d want %0d", nm, miss_cnt, exp_misses); end
`else
    $display("[TB] %s: statistics counters not built", nm);
`endif
  endtask

  initial begin
    nchk = 0;
    nfail = 0;
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_conflict();
    test_flush();
    test_stats("stats_after_flush");
    test_rdy();
    test_reset_miss();
    test_random();
    test_stats("stats_final");
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage and the memory controller's IC port.
- Serves fetch requests, returning hits one cycle later.
- On a miss, holds a single outstanding read to the memory controller and installs the returned word.
- On clr (branch mispredict flush), drops any in-flight miss while keeping cache contents.

Parameters:
- IDX_W, 8, index bits; number of lines = 2^IDX_W.
- ADDR_W, 32, fetch address width. TAG_W = ADDR_W-IDX_W-2 (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, all state holds
- clr  in  1  pipeline flush
- IF_S  in  1  fetch request valid
- IF_pos  in  32  fetch address, word aligned (bits [1:0] ignored)
- IF_ready  out  1  cache can accept a request this cycle (combinational: state==IDLE)
- IF_success  out  1  one-cycle pulse, IF_inst valid
- IF_inst  out  32  fetched instruction
- IC_S  out  1  miss request to memory controller (combinational: state==MISS && !IC_success)
- IC_pos  out  32  miss address, registered
- IC_success  in  1  memory controller fill done (one-cycle pulse)
- IC_value  in  32  fill data

Behaviour:
- Reset (sync, rst high at posedge): state=IDLE, all valid bits 0, IF_success=0, IF_inst=0, IC_pos=0. Tag/data arrays are not reset.
- Priority each posedge: rst > clr > !rdy (hold; IF_success<=0) > normal operation.
- Address split: idx=IF_pos[IDX_W+1:2], tag=IF_pos[ADDR_W-1:IDX_W+2].
- IDLE, IF_S=1, hit (valid[idx] && tag match):
  - IF_success<=1, IF_inst<=data[idx], stay IDLE.
  - Latency 1 cycle; back-to-back hits every cycle.
- IDLE, IF_S=1, miss:
  - IC_pos<={IF_pos[31:2],2'b00}; state<=MISS; IF_success<=0.
  - IC_S rises the next cycle.
- IDLE, IF_S=0: IF_success<=0.
- MISS:
  - IC_S=1 until IC_success is seen; IC_S drops combinationally in the IC_success cycle so the controller never sees a spurious re-request.
  - IF_S and IF_pos are ignored (IF_ready=0). IF must hold its address until IF_success.
- MISS, IC_success=1 at posedge:
  - Write valid/tag/data at the line for IC_pos.
  - IF_success<=1, IF_inst<=IC_value, state<=IDLE.
  - Miss-to-response latency = controller latency + 1 cycle.
- clr=1:
  - state<=IDLE, IF_success<=0; valid array kept.
  - If IC_success=1 in the same cycle, the fill is still written into the array (data is correct for IC_pos) but not returned to IF.
- rdy=0 during MISS: IC_S keeps its value; an IC_success arriving while rdy=0 is not possible (the controller also stalls).
- Conflict: a fill for index i overwrites any prior line at i (no victim handling).
- IF_success is never high in two consecutive cycles for the same request.

Optional Feature:
- Macro ICACHE_STAT_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Each increments on an accepted IDLE request that hits or misses, respectively.
  - Both cleared by rst, not by clr. Both wrap modulo 2^32 and hold when rdy=0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared defines file (existing AddrBus/DataBus, True/False style):
  - ICACHE_IDX_W default and TAG_W derivation.
  - State encoding IDLE=1'b0, MISS=1'b1.
- Sub-module icache_array:
  - valid vector, tag and data arrays.
  - One combinational read port (idx -> valid/tag/data) and one synchronous write port (we, idx, tag, data).
  - valid cleared by rst.
- icache holds the FSM, hit compare and handshake.

Test Plan:
- Cold miss: reset, IF_S=1, IF_pos=0x0000_0010 -> next cycle IC_S=1, IC_pos=0x10. Mem returns IC_success with IC_value=0x0000_0513 -> next cycle IF_success=1, IF_inst=0x0000_0513, IC_S=0 in the IC_success cycle.
- Hit: repeat fetch of 0x10 -> IF_success=1 one cycle later with 0x0000_0513 and no IC_S. Streaming hits on 0x10, 0x14 (both filled) -> IF_success on consecutive cycles.
- Conflict: fill 0x10, then fetch 0x410 (same idx, IDX_W=8) -> miss. After fill, 0x10 misses again.
- Flush mid-miss: miss on 0x20, clr=1 two cycles later -> IC_S=0 next cycle, no IF_success, state IDLE. Flush coinciding with IC_success for 0x20 -> no IF_success, but a later fetch of 0x20 hits.
- rdy low: assert rdy=0 for 3 cycles during a hit request -> no IF_success and no state change; after rdy=1 the request completes normally. Reset during MISS -> IC_S=0 and all lines invalid.
- ICACHE_STAT_EN: 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2. clr leaves the counts unchanged.
